// File: rtl/axil_apb_bridge.sv
// AXI-Lite slave to APB master bridge: one outstanding transfer, registered B/R responses.
// Optional ACCESS-phase timeout enabled by defining AXIL_APB_BRIDGE_TIMEOUT_EN.
module axil_apb_bridge #(
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                       pclk,
    input  logic                       pnreset,
    input  logic                       i_awvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0] i_awaddr,
    output logic                       o_awready,
    input  logic                       i_wvalid,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    output logic                       o_wready,
    output logic                       o_bvalid,
    output logic [1:0]                 o_bresp,
    input  logic                       i_bready,
    input  logic                       i_arvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0] i_araddr,
    output logic                       o_arready,
    output logic                       o_rvalid,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic [1:0]                 o_rresp,
    input  logic                       i_rready,
    output logic                       o_psel,
    output logic                       o_penable,
    output logic                       o_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]  o_paddr,
    output logic [DATA_WIDTH-1:0]      o_pwdata,
    input  logic                       i_pready,
    input  logic [DATA_WIDTH-1:0]      i_prdata
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                     state_q, state_d;
    logic                       rdy_q;
    logic                       aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [AXIL_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]      w_data_q, w_data_d;
    logic                       dir_wr_q, dir_wr_d, prio_wr_q, prio_wr_d;
    logic                       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic                       aw_hs, w_hs, ar_hs, wr_elig, rd_elig, pick_wr;

    // Readies open one cycle after reset release so every output is 0 while in reset.
    assign o_awready = rdy_q & ~aw_full_q;
    assign o_wready  = rdy_q & ~w_full_q;
    assign o_arready = rdy_q & ~ar_full_q;
    assign aw_hs     = i_awvalid & o_awready;
    assign w_hs      = i_wvalid & o_wready;
    assign ar_hs     = i_arvalid & o_arready;

    assign o_psel    = psel_q;
    assign o_penable = penable_q;
    assign o_pwrite  = pwrite_q;
    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;

    // Upper address bits are captured but never forwarded to APB.
    logic unused_addr;
    assign unused_addr = ^{aw_addr_q, ar_addr_q};

`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q | aw_hs;
        w_full_d  = w_full_q | w_hs;
        ar_full_d = ar_full_q | ar_hs;
        aw_addr_d = aw_hs ? i_awaddr : aw_addr_q;
        w_data_d  = w_hs ? i_wdata : w_data_q;
        ar_addr_d = ar_hs ? i_araddr : ar_addr_q;
        dir_wr_d  = dir_wr_q;
        prio_wr_d = prio_wr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        // A request handshaking this cycle is eligible at once, giving SETUP one cycle later.
        wr_elig   = aw_full_d & w_full_d;
        rd_elig   = ar_full_d;
        pick_wr   = wr_elig & (~rd_elig | prio_wr_q);
`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (wr_elig || rd_elig) begin
                    dir_wr_d = pick_wr;
                    psel_d   = 1'b1;
                    pwrite_d = pick_wr;
                    paddr_d  = pick_wr ? aw_addr_d[APB_ADDR_WIDTH-1:0]
                                       : ar_addr_d[APB_ADDR_WIDTH-1:0];
                    pwdata_d = pick_wr ? w_data_d : '0;
                    state_d  = StSetup;
`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (i_pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = StResp;
                    if (dir_wr_q) begin
                        aw_full_d = 1'b0;
                        w_full_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = 2'b00;
                    end else begin
                        ar_full_d = 1'b0;
                        rvalid_d  = 1'b1;
                        rresp_d   = 2'b00;
                        rdata_d   = i_prdata;
                    end
                end
`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = StResp;
                    if (dir_wr_q) begin
                        aw_full_d = 1'b0;
                        w_full_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = 2'b10;
                    end else begin
                        ar_full_d = 1'b0;
                        rvalid_d  = 1'b1;
                        rresp_d   = 2'b10;
                        rdata_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (dir_wr_q && i_bready) begin
                    bvalid_d  = 1'b0;
                    prio_wr_d = 1'b0;
                    state_d   = StIdle;
                end else if (!dir_wr_q && i_rready) begin
                    rvalid_d  = 1'b0;
                    prio_wr_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge pnreset) begin
        if (!pnreset) begin
            state_q   <= StIdle;
            rdy_q     <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            ar_addr_q <= '0;
            dir_wr_q  <= 1'b0;
            prio_wr_q <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rdy_q     <= 1'b1;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            ar_addr_q <= ar_addr_d;
            dir_wr_q  <= dir_wr_d;
            prio_wr_q <= prio_wr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Directed self-checking bench for axil_apb_bridge; outputs sampled on the falling clock edge.
// The timeout case runs only when AXIL_APB_BRIDGE_TIMEOUT_EN is defined.
module tb_axil_apb_bridge;

    logic        pclk = 1'b0;
    logic        pnreset;
    logic        i_awvalid, i_wvalid, i_arvalid, i_bready, i_rready, i_pready;
    logic [31:0] i_awaddr, i_araddr;
    logic [7:0]  i_wdata, i_prdata;
    logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid;
    logic        o_psel, o_penable, o_pwrite;
    logic [1:0]  o_bresp, o_rresp;
    logic [7:0]  o_rdata, o_pwdata;
    logic [15:0] o_paddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    axil_apb_bridge #(
        .AXIL_ADDR_WIDTH(32),
        .APB_ADDR_WIDTH (16),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk     (pclk),
        .pnreset  (pnreset),
        .i_awvalid(i_awvalid),
        .i_awaddr (i_awaddr),
        .o_awready(o_awready),
        .i_wvalid (i_wvalid),
        .i_wdata  (i_wdata),
        .o_wready (o_wready),
        .o_bvalid (o_bvalid),
        .o_bresp  (o_bresp),
        .i_bready (i_bready),
        .i_arvalid(i_arvalid),
        .i_araddr (i_araddr),
        .o_arready(o_arready),
        .o_rvalid (o_rvalid),
        .o_rdata  (o_rdata),
        .o_rresp  (o_rresp),
        .i_rready (i_rready),
        .o_psel   (o_psel),
        .o_penable(o_penable),
        .o_pwrite (o_pwrite),
        .o_paddr  (o_paddr),
        .o_pwdata (o_pwdata),
        .i_pready (i_pready),
        .i_prdata (i_prdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        pnreset   = 1'b0;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        i_awaddr  = '0;   i_araddr = '0;   i_wdata   = '0;
        i_bready  = 1'b0; i_rready = 1'b0; i_pready  = 1'b0; i_prdata = '0;
        repeat (2) @(negedge pclk);
        pnreset = 1'b1;
        @(negedge pclk);
    endtask

    // Waits (bounded) for a SETUP cycle, checks direction/address, returns in the ACCESS cycle.
    task automatic await_setup(input string tag, input logic exp_wr, input logic [15:0] exp_addr);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_psel && !o_penable) begin
                found = 1;
                break;
            end
            @(negedge pclk);
        end
        check_eq({tag, " setup seen"}, 32'(found), 32'd1);
        check_eq({tag, " pwrite"}, 32'(o_pwrite), 32'(exp_wr));
        check_eq({tag, " paddr"}, 32'(o_paddr), 32'(exp_addr));
        @(negedge pclk);
    endtask

    // Cycles 1..4 of a write of 0x5A to 0x3 accepted in the previous cycle, pready=bready=1.
    task automatic write_tail(input string tag);
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        check_eq({tag, " c1 psel"}, 32'(o_psel), 32'd1);
        check_eq({tag, " c1 penable"}, 32'(o_penable), 32'd0);
        check_eq({tag, " c1 paddr"}, 32'(o_paddr), 32'h3);
        check_eq({tag, " c1 pwrite"}, 32'(o_pwrite), 32'd1);
        check_eq({tag, " c1 pwdata"}, 32'(o_pwdata), 32'h5A);
        @(negedge pclk);
        check_eq({tag, " c2 psel"}, 32'(o_psel), 32'd1);
        check_eq({tag, " c2 penable"}, 32'(o_penable), 32'd1);
        check_eq({tag, " c2 bvalid"}, 32'(o_bvalid), 32'd0);
        @(negedge pclk);
        check_eq({tag, " c3 bvalid"}, 32'(o_bvalid), 32'd1);
        check_eq({tag, " c3 bresp"}, 32'(o_bresp), 32'd0);
        check_eq({tag, " c3 psel"}, 32'(o_psel), 32'd0);
        @(negedge pclk);
        check_eq({tag, " c4 bvalid"}, 32'(o_bvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        pnreset = 1'b0;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        i_awaddr = '0; i_araddr = '0; i_wdata = '0;
        i_bready = 1'b0; i_rready = 1'b0; i_pready = 1'b0; i_prdata = '0;
        #12;
        check_eq("rst psel", 32'(o_psel), 32'd0);
        check_eq("rst awready", 32'(o_awready), 32'd0);
        check_eq("rst bvalid", 32'(o_bvalid), 32'd0);
        check_eq("rst rvalid", 32'(o_rvalid), 32'd0);
        check_eq("rst paddr", 32'(o_paddr), 32'd0);
        apply_reset();
        check_eq("post-rst awready", 32'(o_awready), 32'd1);
        check_eq("post-rst arready", 32'(o_arready), 32'd1);

        // Basic write, zero-wait APB.
        i_pready = 1'b1; i_bready = 1'b1; i_rready = 1'b1;
        i_awvalid = 1'b1; i_awaddr = 32'h0000_0003; i_wvalid = 1'b1; i_wdata = 8'h5A;
        write_tail("wr");

        // W two cycles ahead of AW.
        i_wvalid = 1'b1; i_wdata = 8'h5A;
        @(negedge pclk);
        i_wvalid = 1'b0;
        check_eq("wfirst wready", 32'(o_wready), 32'd0);
        check_eq("wfirst psel a", 32'(o_psel), 32'd0);
        @(negedge pclk);
        check_eq("wfirst psel b", 32'(o_psel), 32'd0);
        i_awvalid = 1'b1; i_awaddr = 32'h0000_0003;
        write_tail("wfirst");

        // Read with 3 wait cycles; upper address bits dropped.
        i_pready = 1'b0; i_prdata = 8'hC3;
        i_arvalid = 1'b1; i_araddr = 32'h0001_0007;
        @(negedge pclk);
        i_arvalid = 1'b0;
        check_eq("rd c1 psel", 32'(o_psel), 32'd1);
        check_eq("rd c1 penable", 32'(o_penable), 32'd0);
        check_eq("rd c1 paddr", 32'(o_paddr), 32'h7);
        check_eq("rd c1 pwrite", 32'(o_pwrite), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            check_eq($sformatf("rd access%0d penable", k), 32'(o_penable), 32'd1);
            check_eq($sformatf("rd access%0d rvalid", k), 32'(o_rvalid), 32'd0);
            if (k == 3) i_pready = 1'b1;
        end
        @(negedge pclk);
        i_pready = 1'b0;
        check_eq("rd rvalid", 32'(o_rvalid), 32'd1);
        check_eq("rd rdata", 32'(o_rdata), 32'hC3);
        check_eq("rd rresp", 32'(o_rresp), 32'd0);
        check_eq("rd penable off", 32'(o_penable), 32'd0);
        @(negedge pclk);
        check_eq("rd rvalid clr", 32'(o_rvalid), 32'd0);

        // Round-robin arbitration from reset.
        apply_reset();
        i_pready = 1'b1; i_bready = 1'b1; i_rready = 1'b1;
        i_awvalid = 1'b1; i_awaddr = 32'h10; i_wvalid = 1'b1; i_wdata = 8'h11;
        i_arvalid = 1'b1; i_araddr = 32'h20;
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        await_setup("pair1 first", 1'b1, 16'h10);
        await_setup("pair1 second", 1'b0, 16'h20);
        repeat (3) @(negedge pclk);
        i_awvalid = 1'b1; i_awaddr = 32'h30; i_wvalid = 1'b1; i_wdata = 8'h31;
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        await_setup("lone wr", 1'b1, 16'h30);
        repeat (3) @(negedge pclk);
        i_awvalid = 1'b1; i_awaddr = 32'h12; i_wvalid = 1'b1; i_wdata = 8'h13;
        i_arvalid = 1'b1; i_araddr = 32'h22;
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        await_setup("pair2 first", 1'b0, 16'h22);
        await_setup("pair2 second", 1'b1, 16'h12);
        repeat (3) @(negedge pclk);

        // B back-pressure with a read queued behind it.
        i_bready = 1'b0;
        i_awvalid = 1'b1; i_awaddr = 32'h40; i_wvalid = 1'b1; i_wdata = 8'h41;
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        repeat (2) @(negedge pclk);
        check_eq("bp bvalid c3", 32'(o_bvalid), 32'd1);
        i_arvalid = 1'b1; i_araddr = 32'h50;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            i_arvalid = 1'b0;
            check_eq($sformatf("bp hold%0d bvalid", k), 32'(o_bvalid), 32'd1);
            check_eq($sformatf("bp hold%0d bresp", k), 32'(o_bresp), 32'd0);
            check_eq($sformatf("bp hold%0d psel", k), 32'(o_psel), 32'd0);
        end
        check_eq("bp ar taken", 32'(o_arready), 32'd0);
        i_bready = 1'b1;
        @(negedge pclk);
        check_eq("bp bvalid clr", 32'(o_bvalid), 32'd0);
        check_eq("bp idle psel", 32'(o_psel), 32'd0);
        await_setup("bp queued rd", 1'b0, 16'h50);
        repeat (3) @(negedge pclk);

        // Asynchronous reset during ACCESS.
        i_pready = 1'b0;
        i_awvalid = 1'b1; i_awaddr = 32'h60; i_wvalid = 1'b1; i_wdata = 8'h61;
        @(negedge pclk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge pclk);
        check_eq("arst pre penable", 32'(o_penable), 32'd1);
        #2 pnreset = 1'b0;
        #1;
        check_eq("arst psel", 32'(o_psel), 32'd0);
        check_eq("arst penable", 32'(o_penable), 32'd0);
        check_eq("arst pwrite", 32'(o_pwrite), 32'd0);
        check_eq("arst paddr", 32'(o_paddr), 32'd0);
        check_eq("arst awready", 32'(o_awready), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        pnreset = 1'b1; i_pready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            check_eq($sformatf("arst after%0d resp", k), 32'(o_bvalid | o_rvalid), 32'd0);
            check_eq($sformatf("arst after%0d psel", k), 32'(o_psel), 32'd0);
        end

`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
        // ACCESS timeout after 4 cycles gives SLVERR with zero data.
        i_pready = 1'b0; i_prdata = 8'hFF; i_rready = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h70;
        @(negedge pclk);
        i_arvalid = 1'b0;
        await_setup("to rd", 1'b0, 16'h70);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("to access%0d penable", k), 32'(o_penable), 32'd1);
            @(negedge pclk);
        end
        check_eq("to rvalid", 32'(o_rvalid), 32'd1);
        check_eq("to rresp", 32'(o_rresp), 32'd2);
        check_eq("to rdata", 32'(o_rdata), 32'd0);
        check_eq("to psel", 32'(o_psel), 32'd0);
        i_rready = 1'b1;
        @(negedge pclk);
        check_eq("to rvalid clr", 32'(o_rvalid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axil_apb_bridge.md
Name: axil_apb_bridge

Overview:
- AXI-Lite slave to APB master bridge; sits directly upstream of the APB register slaves in the DMA subsystem and drives their psel/penable/pwrite/paddr/pwdata.
- Accepts one AXI-Lite read or write at a time, converts it into a two-phase APB transfer (SETUP, ACCESS), and returns a registered B or R response.
- Single outstanding transaction; no bursts, no byte strobes.

Parameters:
- AXIL_ADDR_WIDTH, 32, AXI-Lite address width.
- APB_ADDR_WIDTH, 16, APB address width; must be ≤ AXIL_ADDR_WIDTH.
- DATA_WIDTH, 8, shared AXI-Lite/APB data width.
- TIMEOUT_CYCLES, 64, ACCESS-phase wait limit (used only with the optional feature).

Ports:
- pclk  in  1  clock
- pnreset  in  1  asynchronous active-low reset
- i_awvalid  in  1  write address valid
- i_awaddr  in  AXIL_ADDR_WIDTH  write address
- o_awready  out  1  write address ready
- i_wvalid  in  1  write data valid
- i_wdata  in  DATA_WIDTH  write data
- o_wready  out  1  write data ready
- o_bvalid  out  1  write response valid
- o_bresp  out  2  write response
- i_bready  in  1  write response ready
- i_arvalid  in  1  read address valid
- i_araddr  in  AXIL_ADDR_WIDTH  read address
- o_arready  out  1  read address ready
- o_rvalid  out  1  read data valid
- o_rdata  out  DATA_WIDTH  read data
- o_rresp  out  2  read response
- i_rready  in  1  read data ready
- o_psel, o_penable, o_pwrite  out  1 each  APB control
- o_paddr  out  APB_ADDR_WIDTH  APB address = captured addr[APB_ADDR_WIDTH-1:0]; upper bits are ignored
- o_pwdata  out  DATA_WIDTH  APB write data
- i_pready  in  1  APB ready
- i_prdata  in  DATA_WIDTH  APB read data

Behaviour:
- Reset (pnreset=0, asynchronous): every output is 0, all capture buffers are empty, FSM is IDLE, priority flag is write-first.
- Capture buffers: AW, W and AR each have a one-entry buffer with a valid flag.
  - o_awready = ~aw_full, o_wready = ~w_full, o_arready = ~ar_full.
  - A buffer is filled on valid&&ready.
  - AW and W are accepted independently, in any order.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A write is eligible when aw_full&&w_full; a read is eligible when ar_full.
  - If both are eligible, choose opposite to the last served direction (round-robin).
  - Go to SETUP with the chosen direction latched.
- SETUP:
  - psel=1, penable=0; paddr, pwrite and pwdata are valid.
  - Lasts exactly 1 cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata are held stable.
  - Stays until i_pready=1.
  - On that edge: capture i_prdata (read), free the used buffer(s), drop psel/penable next cycle, go to RESP.
- RESP:
  - Write: bvalid=1, bresp=2'b00 until i_bready.
  - Read: rvalid=1, rdata=captured value, rresp=2'b00 until i_rready.
  - On the handshake, return to IDLE and update the priority flag.
- Latency: AW+W accepted at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → with zero-wait pready, bvalid at cycle 3. Read timing is identical.
- Freed buffers may accept new requests while RESP is still pending; new requests wait in IDLE.
- Response valid and data are register outputs; nothing combinational goes from APB inputs to AXI outputs.
- i_pready outside ACCESS is ignored.
- Reset asserted mid-transfer aborts it; no response is issued afterwards.

Optional Feature:
- Macro AXIL_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If i_pready is still low after TIMEOUT_CYCLES ACCESS cycles, the bridge drops psel/penable, frees the buffers and enters RESP with bresp/rresp=2'b10 (SLVERR); rdata=0 for reads.
  - The counter clears on entry to SETUP.
- Undefined: no counter logic; ACCESS waits indefinitely.

Test Plan:
- Write 0x5A to awaddr 0x0000_0003, pready tied 1 → one SETUP cycle, one ACCESS cycle with paddr=0x0003, pwrite=1, pwdata=0x5A; bvalid at cycle 3, bresp=0.
- W presented 2 cycles before AW → no APB activity until AW is accepted; the transfer is then identical to the previous case.
- Read araddr 0x1_0007, prdata=0xC3, pready low for 3 ACCESS cycles → paddr=0x0007; rvalid one cycle after pready; rdata=0xC3; penable high for 4 cycles.
- Write and read both eligible in the same IDLE cycle after reset → write served first, read second; repeat the pair → order alternates.
- bready held low 5 cycles → bvalid stays 1, bresp stable; a new AR accepted meanwhile is started only after the B handshake.
- Reset pulsed during ACCESS → all outputs 0 asynchronously, no B/R after release.
- With the macro defined, TIMEOUT_CYCLES=4, pready never asserted → after 4 ACCESS cycles rresp=2'b10, rdata=0.
